// File: rtl/sudoku_grid_validator.sv
// sudoku_grid_validator: sweeps all 27 Sudoku groups through a 1-cycle read port and reports consistency, completeness and the first violation
// Ports: clk, rst_n (async active-low); start (sampled in IDLE); rd_row/rd_col address out, rd_data one cycle later;
//        busy, done (sticky), err (sticky), err_kind/err_group/err_row/err_col of the first violation, complete (no empty cell seen).
module sudoku_grid_validator #(
  parameter bit ALLOW_EMPTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] rd_row,
  output logic [3:0] rd_col,
  input  logic [3:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_kind,
  output logic [3:0] err_group,
  output logic [3:0] err_row,
  output logic [3:0] err_col,
  output logic       complete
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic iss, p_vld, last, dup, bad;
  logic [4:0] g, p_g;
  logic [3:0] i, p_i, p_row, p_col, a_row, a_col, bi, qb, qi;
  logic [8:0] mask, mask_in, bit_v;
  logic [1:0] p_type;
  // g-9 and g-18 fit in 4 bits, so the low nibble arithmetic wraps to the right index
  always_comb begin
    bi = g[3:0] - 4'd2;
    qb = (bi < 4'd3) ? 4'd0 : (bi < 4'd6) ? 4'd1 : 4'd2;
    qi = (i < 4'd3) ? 4'd0 : (i < 4'd6) ? 4'd1 : 4'd2;
    a_row = (g < 5'd9) ? g[3:0] : (g < 5'd18) ? i : 4'd3 * qb + qi;
    a_col = (g < 5'd9) ? i : (g < 5'd18) ? g[3:0] - 4'd9 : 4'd3 * (bi - 4'd3 * qb) + (i - 4'd3 * qi);
  end
  assign busy = (state == SWEEP);
  assign rd_row = (busy && iss) ? a_row : 4'd0;
  assign rd_col = (busy && iss) ? a_col : 4'd0;
  assign mask_in = (p_i == 4'd0) ? 9'd0 : mask;
  // 0 and values above 9 shift the one-hot out of range, giving an empty bit
  assign bit_v = 9'd1 << (rd_data - 4'd1);
  assign dup = |(mask_in & bit_v);
  assign bad = dup || (rd_data > 4'd9) || (!ALLOW_EMPTY && rd_data == 4'd0);
  assign p_type = (p_g < 5'd9) ? 2'd0 : (p_g < 5'd18) ? 2'd1 : 2'd2;
  assign last = p_vld && (p_g == 5'd26) && (p_i == 4'd8);
  always_comb state_nx = (state == IDLE) ? (start ? SWEEP : IDLE) : (last ? IDLE : SWEEP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g <= 5'd0;
      i <= 4'd0;
      iss <= 1'b0;
      p_vld <= 1'b0;
      p_g <= 5'd0;
      p_i <= 4'd0;
      p_row <= 4'd0;
      p_col <= 4'd0;
      mask <= 9'd0;
      done <= 1'b0;
      err <= 1'b0;
      err_kind <= 2'd0;
      err_group <= 4'd0;
      err_row <= 4'd0;
      err_col <= 4'd0;
      complete <= 1'b0;
    end else if (state == IDLE && start) begin
      g <= 5'd0;
      i <= 4'd0;
      iss <= 1'b1;
      p_vld <= 1'b0;
      mask <= 9'd0;
      done <= 1'b0;
      err <= 1'b0;
      err_kind <= 2'd0;
      err_group <= 4'd0;
      err_row <= 4'd0;
      err_col <= 4'd0;
      complete <= 1'b1;
    end else if (busy) begin
      p_vld <= iss;
      if (iss) begin
        p_g <= g;
        p_i <= i;
        p_row <= a_row;
        p_col <= a_col;
        g <= (i == 4'd8) ? g + 5'd1 : g;
        i <= (i == 4'd8) ? 4'd0 : i + 4'd1;
        iss <= !(g == 5'd26 && i == 4'd8);
      end
      if (p_vld) begin
        mask <= mask_in | bit_v;
        if (rd_data == 4'd0) complete <= 1'b0;
        if (bad && !err) begin
          err <= 1'b1;
          err_kind <= dup ? p_type : 2'd3;
          err_group <= (p_type == 2'd0) ? p_g[3:0] : (p_type == 2'd1) ? p_g[3:0] - 4'd9 : p_g[3:0] - 4'd2;
          err_row <= p_row;
          err_col <= p_col;
        end
        if (last) done <= 1'b1;
      end
    end
  end
endmodule
